// File: rtl/multicycle_main_control.sv
// multicycle_main_control
// Main control FSM of the multicycle datapath. It decodes the 6-bit opcode
// held in the instruction register, sequences fetch / decode / execute /
// memory / writeback, and drives every datapath enable and mux select,
// including the 3-bit ALUOP code consumed by the ALU control decoder.
// Memory states stall until mem_ready_i. A saturating wait counter raises a
// sticky mem_timeout_o flag after WAIT_LIMIT consecutive stall cycles.
// Unknown opcodes pulse illegal_op_o for the DECODE cycle and restart fetch.
//
// Ports
//   clk_i          rising-edge clock
//   rst_n_i        synchronous active-low reset
//   opcode_i       IR[31:26], sampled in DECODE only
//   mem_ready_i    memory completes the access this cycle
//   PCWrite_o      unconditional PC load
//   PCWriteCond_o  PC load if ALU zero
//   IorD_o         0 = PC address, 1 = ALUOut address
//   MemRead_o      memory read request
//   MemWrite_o     memory write request
//   IRWrite_o      IR load
//   MemtoReg_o     1 = MDR to register file
//   RegDst_o       1 = rd, 0 = rt
//   RegWrite_o     register-file write
//   ALUSrcA_o      0 = PC, 1 = reg A
//   ALUSrcB_o      00 reg B, 01 const 4, 10 ext imm, 11 sext imm << 2
//   ZeroExt_o      1 = zero-extend immediate (andi/ori)
//   PCSource_o     00 ALU result, 01 ALUOut, 10 jump target
//   ALUOP_o        000 none, 100 add, 111 sub, 101 and, 110 or, 010 R-type
//   illegal_op_o   one-cycle pulse on unknown opcode
//   mem_timeout_o  sticky memory timeout flag
//   state_o        current state, for debug
module multicycle_main_control #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       MemtoReg_o,
    output logic       RegDst_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic       ZeroExt_o,
    output logic [1:0] PCSource_o,
    output logic [2:0] ALUOP_o,
    output logic       illegal_op_o,
    output logic       mem_timeout_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ANDI_EXEC = 4'd12,
        S_ORI_EXEC  = 4'd13,
        S_IMM_WB    = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b111;
    localparam logic [2:0] ALU_AND  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_RTYP = 3'b010;

    localparam logic [7:0] WAIT_LIMIT_C = 8'(WAIT_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;
    // Remembers lw vs sw past DECODE, since opcode_i is only valid there.
    logic       is_sw_q, is_sw_d;
    logic       stall_s;

    // State, wait counter, timeout flag and store marker registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            is_sw_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            is_sw_q       <= is_sw_d;
        end
    end

    // Next-state decode, including opcode dispatch in DECODE.
    always_comb begin
        state_d = state_q;
        is_sw_d = is_sw_q;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready_i) state_d = S_DECODE;
                else             state_d = S_FETCH;
            end
            S_DECODE: begin
                is_sw_d = (opcode_i == OP_SW);
                case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    OP_ANDI:      state_d = S_ANDI_EXEC;
                    OP_ORI:       state_d = S_ORI_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (is_sw_q) state_d = S_MEM_WRITE;
                else         state_d = S_MEM_READ;
            end
            S_MEM_READ: begin
                if (mem_ready_i) state_d = S_MEM_WB;
                else             state_d = S_MEM_READ;
            end
            S_MEM_WRITE: begin
                if (mem_ready_i) state_d = S_FETCH;
                else             state_d = S_MEM_WRITE;
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC,
            S_ANDI_EXEC,
            S_ORI_EXEC:  state_d = S_IMM_WB;
            S_MEM_WB,
            S_R_WB,
            S_BRANCH,
            S_JUMP,
            S_IMM_WB:    state_d = S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    // Saturating stall counter; the timeout flag is sticky until reset.
    always_comb begin
        stall_s = ((state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                   (state_q == S_MEM_WRITE)) && !mem_ready_i;
        if (stall_s) begin
            if (wait_cnt_q >= WAIT_LIMIT_C) wait_cnt_d = WAIT_LIMIT_C;
            else                            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = 8'd0;
        end
        if (stall_s && (wait_cnt_d == WAIT_LIMIT_C)) mem_timeout_d = 1'b1;
        else                                         mem_timeout_d = mem_timeout_q;
    end

    // Moore output decode; FETCH qualifies IRWrite/PCWrite with mem_ready.
    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemtoReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ZeroExt_o     = 1'b0;
        PCSource_o    = 2'b00;
        ALUOP_o       = ALU_NONE;
        illegal_op_o  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                ALUOP_o   = ALU_ADD;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
            end
            S_DECODE: begin
                ALUSrcB_o = 2'b11;
                ALUOP_o   = ALU_ADD;
                case (opcode_i)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J,
                    OP_ADDI, OP_ANDI, OP_ORI: illegal_op_o = 1'b0;
                    default:                  illegal_op_o = 1'b1;
                endcase
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALUOP_o   = ALU_ADD;
            end
            S_MEM_READ: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUOP_o   = ALU_RTYP;
            end
            S_R_WB: begin
                RegWrite_o = 1'b1;
                RegDst_o   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUOP_o       = ALU_SUB;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
            end
            S_JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = 2'b10;
            end
            S_ANDI_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ZeroExt_o = 1'b1;
                ALUOP_o   = ALU_AND;
            end
            S_ORI_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ZeroExt_o = 1'b1;
                ALUOP_o   = ALU_OR;
            end
            S_IMM_WB: begin
                RegWrite_o = 1'b1;
            end
            default: begin
                ALUOP_o = ALU_NONE;
            end
        endcase
    end

    assign mem_timeout_o = mem_timeout_q;
    assign state_o       = state_q;

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle datapath; it is the producer side of the 3-bit ALUOP interface that the ALU control decoder consumes.
- Decodes the 6-bit opcode from the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives all datapath enables and muxes, including ALUOP.
- Stalls on memory states until a mem_ready handshake and flags memory timeouts and illegal opcodes.

Parameters:
- WAIT_LIMIT, 255: max consecutive stall cycles in a memory state before mem_timeout sets; 8-bit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- opcode  input  6  instruction bits [31:26] from IR; sampled in DECODE only.
- mem_ready  input  1  memory completes the access this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if ALU zero.
- IorD  output  1  0 = PC address, 1 = ALUOut address.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  IR load.
- MemtoReg  output  1  1 = MDR to register file.
- RegDst  output  1  1 = rd, 0 = rt.
- RegWrite  output  1  register-file write.
- ALUSrcA  output  1  0 = PC, 1 = reg A.
- ALUSrcB  output  2  00 = reg B, 01 = const 4, 10 = ext imm, 11 = sext imm << 2.
- ZeroExt  output  1  1 = zero-extend imm (andi/ori).
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUOP  output  3  000 none, 100 add (lw/sw/addi/PC+4), 111 sub (beq), 101 and, 110 or, 010 R-type.
- illegal_op  output  1  one-cycle pulse on unknown opcode.
- mem_timeout  output  1  sticky timeout flag.
- state  output  4  current state, for debug.

Behaviour:
- State register, wait counter, and mem_timeout update on posedge clk.
- rst_n=0 at an edge forces state=IDLE, counter=0, mem_timeout=0; this overrides everything, including a mid-instruction reset.
- Outputs are Moore-decoded from state, except IRWrite/PCWrite in FETCH, which are qualified by mem_ready.
- Any output not listed for a state is 0. In IDLE all outputs are 0 and ALUOP=000.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ANDI_EXEC=12, ORI_EXEC=13, IMM_WB=14. Code 15 is unreachable and recovers to IDLE.
- IDLE: always goes to FETCH next cycle.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=100, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOP=100. Next state by opcode:
  - 100011 lw or 101011 sw -> MEM_ADDR.
  - 000000 -> R_EXEC.
  - 000100 -> BRANCH.
  - 000010 -> JUMP.
  - 001000 -> ADDI_EXEC.
  - 001100 -> ANDI_EXEC.
  - 001101 -> ORI_EXEC.
  - Other opcodes -> FETCH, with illegal_op=1 for that DECODE cycle only.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOP=100. Next state is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead=1, IorD=1. Stalls until mem_ready, then goes to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Stalls until mem_ready, then goes to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOP=010. Next state R_WB.
- R_WB: RegWrite=1, RegDst=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOP=111, PCWriteCond=1, PCSource=01. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOP=100.
- ANDI_EXEC: same as ADDI_EXEC plus ZeroExt=1, with ALUOP=101.
- ORI_EXEC: same as ANDI_EXEC with ALUOP=110.
- All three immediate-execute states go to IMM_WB.
- IMM_WB: RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH.
- Latency with mem_ready held at 1, in cycles from entering FETCH to re-entering FETCH:
  - lw 5, sw 4, R-type 4, addi/andi/ori 4, beq 3, j 3, illegal 2.
  - Each mem_ready=0 cycle in a memory state adds 1.
- Wait counter:
  - Increments each cycle in FETCH, MEM_READ, or MEM_WRITE with mem_ready=0.
  - Clears on mem_ready=1 and in every other state.
  - Saturates at WAIT_LIMIT; on reaching WAIT_LIMIT, mem_timeout sets.
  - The FSM keeps waiting after a timeout; mem_timeout clears only on reset.
- opcode changing outside DECODE has no effect.

Test Plan:
- Reset then R-type: rst_n=0 for 2 cycles, then rst_n=1, opcode=000000, mem_ready=1 -> state sequence 0,1,2,7,8,1; ALUOP=010 in R_EXEC; RegWrite=1 and RegDst=1 in R_WB only; all outputs 0 during reset/IDLE.
- lw with 3-cycle stall: opcode=100011, mem_ready low for 3 cycles in MEM_READ -> state held at 4 for 4 cycles; MemRead=1, IorD=1 throughout; MEM_WB gives RegWrite=1, MemtoReg=1; total 8 cycles.
- andi/ori/beq: ALUOP=101 with ZeroExt=1 for andi; ALUOP=110 for ori; beq gives ALUOP=111, PCWriteCond=1, PCSource=01, 3 cycles.
- Illegal opcode 111111 -> illegal_op pulses exactly 1 cycle in DECODE; next state FETCH; no RegWrite/MemWrite asserted.
- Timeout with WAIT_LIMIT=4 and mem_ready=0 in FETCH -> mem_timeout rises after the 4th stall cycle; IRWrite=PCWrite=0 throughout; stays high after mem_ready=1 until rst_n=0.
- Reset mid-instruction: rst_n=0 during MEM_WRITE -> next cycle state=IDLE, MemWrite=0, counter=0; then resumes FETCH.
